// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Types and constants shared by the tone generator and the level-metering path.
//   sample_t      : signed 16-bit audio sample
//   DB_THRESH_*   : dB breakpoints (30, 40, 50, 60, 70); the meter uses the same set
//   AMP_LEVEL_*   : peak amplitude for each dB band
//   tone_state_t  : tone generator control states
//   db_to_amp()   : dB code -> peak amplitude
// -----------------------------------------------------------------------------
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam logic [15:0] DB_THRESH_0 = 16'd30;
    localparam logic [15:0] DB_THRESH_1 = 16'd40;
    localparam logic [15:0] DB_THRESH_2 = 16'd50;
    localparam logic [15:0] DB_THRESH_3 = 16'd60;
    localparam logic [15:0] DB_THRESH_4 = 16'd70;

    localparam logic [15:0] AMP_LEVEL_0 = 16'd50;
    localparam logic [15:0] AMP_LEVEL_1 = 16'd300;
    localparam logic [15:0] AMP_LEVEL_2 = 16'd1200;
    localparam logic [15:0] AMP_LEVEL_3 = 16'd5000;
    localparam logic [15:0] AMP_LEVEL_4 = 16'd14000;
    localparam logic [15:0] AMP_LEVEL_5 = 16'd28000;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RAMP = 2'd2
    } tone_state_t;

    function automatic logic [15:0] db_to_amp(input logic [15:0] db);
        logic [15:0] amp;
        if (db <= DB_THRESH_0)      amp = AMP_LEVEL_0;
        else if (db <= DB_THRESH_1) amp = AMP_LEVEL_1;
        else if (db <= DB_THRESH_2) amp = AMP_LEVEL_2;
        else if (db <= DB_THRESH_3) amp = AMP_LEVEL_3;
        else if (db <= DB_THRESH_4) amp = AMP_LEVEL_4;
        else                        amp = AMP_LEVEL_5;
        return amp;
    endfunction

endpackage

// File: rtl/db_amp_ramp.sv
// -----------------------------------------------------------------------------
// db_amp_ramp
// Holds the target amplitude (latched from a dB code) and the current amplitude,
// which slews toward the target by at most RAMP_STEP per sample tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   db_load    : strobe; db_target is mapped and latched into the target
//   db_target  : requested level in dB
//   tick       : sample tick; the current amplitude takes one ramp step
//   amp_cur    : current amplitude (0..28000)
//   busy       : current amplitude differs from target
// -----------------------------------------------------------------------------
module db_amp_ramp #(
    parameter int RAMP_STEP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        db_load,
    input  logic [15:0] db_target,
    input  logic        tick,
    output logic [15:0] amp_cur,
    output logic        busy
);
    import audio_pkg::*;

    localparam logic [15:0] STEP = 16'(RAMP_STEP);

    logic [15:0] r_amp_cur;
    logic [15:0] r_amp_tgt;
    logic        w_up;
    logic [15:0] w_gap;
    logic [15:0] w_amp_next;

    assign w_up  = (r_amp_tgt > r_amp_cur);
    assign w_gap = w_up ? (r_amp_tgt - r_amp_cur) : (r_amp_cur - r_amp_tgt);

    // Final step lands exactly on the target, so the ramp never overshoots.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_amp_next = r_amp_tgt;
        if (w_gap > STEP) begin
            w_amp_next = w_up ? (r_amp_cur + STEP) : (r_amp_cur - STEP);
        end
    end

    // A load coinciding with a tick: the tick steps toward the old target,
    // because both registers update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments and an async reset; every register here is reset.
        if (!rst_n) begin
            r_amp_cur <= '0;
            r_amp_tgt <= '0;
        end else begin
            if (tick)    r_amp_cur <= w_amp_next;
            if (db_load) r_amp_tgt <= db_to_amp(db_target);
        end
    end

    assign amp_cur = r_amp_cur;
    assign busy    = (r_amp_cur != r_amp_tgt);

endmodule

// File: rtl/db_tone_generator.sv
// -----------------------------------------------------------------------------
// db_tone_generator
// Triangle-tone audio source at a requested dB level for self-test/calibration.
// A divider produces one sample tick every CLK_DIV clocks; each tick advances
// the phase accumulator and ramps the amplitude. Samples leave through a short
// pipeline, 2 cycles after their tick.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 1 = generate samples, 0 = stream halted (phase/amplitude held)
//   db_target   : requested level in dB; latched on db_load (any state)
//   db_load     : single-cycle load strobe
//   tone_step   : phase increment per sample
//   audio_data  : signed sample, valid while data_valid is high
//   data_valid  : one-cycle sample strobe
//   busy        : amplitude still ramping toward target
// Build option: define DB_TONE_DITHER_EN to add +/-1 LFSR dither to each sample.
// -----------------------------------------------------------------------------
module db_tone_generator #(
    parameter int CLK_DIV   = 1134,
    parameter int RAMP_STEP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] db_target,
    input  logic        db_load,
    input  logic [15:0] tone_step,
    output logic [15:0] audio_data,
    output logic        data_valid,
    output logic        busy
);
    import audio_pkg::*;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    tone_state_t        r_state;
    tone_state_t        w_state_next;
    logic [15:0]        r_div_cnt;
    logic [15:0]        r_phase;
    logic               r_s1_valid;
    sample_t            r_s1_tri_s;
    sample_t            r_audio;
    logic               r_valid;

    logic               w_run;
    logic               w_tick;
    logic               w_busy;
    logic [15:0]        w_amp_cur;
    logic [14:0]        w_tri;
    sample_t            w_tri_s;
    logic signed [31:0] w_tri_ext;
    logic signed [31:0] w_amp_ext;
    logic signed [31:0] w_product;
    logic signed [31:0] w_out;

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (enable) w_state_next = ST_RUN;
            ST_RUN: begin
                if (!enable)     w_state_next = ST_IDLE;
                else if (w_busy) w_state_next = ST_RAMP;
            end
            ST_RAMP: begin
                if (!enable)      w_state_next = ST_IDLE;
                else if (!w_busy) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The divider only runs once the FSM has left IDLE, so the first tick after
    // enable rises lands CLK_DIV cycles later.
    assign w_run  = (r_state != ST_IDLE);
    assign w_tick = w_run && enable && (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_phase   <= '0;
        end else begin
            if (w_run && enable) r_div_cnt <= w_tick ? 16'd0 : (r_div_cnt + 16'd1);
            else                 r_div_cnt <= '0;
            if (w_tick)          r_phase   <= r_phase + tone_step;
        end
    end

    db_amp_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_amp_ramp (
        .clk       (clk),
        .rst_n     (rst_n),
        .db_load   (db_load),
        .db_target (db_target),
        .tick      (w_tick),
        .amp_cur   (w_amp_cur),
        .busy      (w_busy)
    );

    // ---------------- datapath ----------------
    // Triangle from the pre-increment phase: folds the upper half back down,
    // then centres 0..32767 around zero.
    assign w_tri   = r_phase[15] ? ~r_phase[14:0] : r_phase[14:0];
    assign w_tri_s = $signed({1'b0, w_tri}) - 16'sd16384;

    // Multiply uses the amplitude after this tick's ramp step.
    assign w_tri_ext = {{16{r_s1_tri_s[15]}}, r_s1_tri_s};
    assign w_amp_ext = {16'd0, w_amp_cur};
    assign w_product = w_tri_ext * w_amp_ext;

`ifdef DB_TONE_DITHER_EN
    logic [15:0] r_lfsr;
    logic        r_s1_dith;
    logic        w_lfsr_fb;

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr    <= LFSR_SEED;
            r_s1_dith <= 1'b0;
        end else if (w_tick) begin
            r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
            r_s1_dith <= r_lfsr[0];
        end
    end

    // |tri_s*amp>>>14| <= 28000, so +/-1 stays well inside 16 bits.
    assign w_out = (w_product >>> 14) + (r_s1_dith ? 32'sd1 : -32'sd1);
`else
    assign w_out = w_product >>> 14;
`endif

    // Dropping enable kills both pipeline stages; audio_data keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_tri_s <= '0;
            r_valid    <= 1'b0;
            r_audio    <= '0;
        end else begin
            r_s1_valid <= w_tick;
            if (w_tick) r_s1_tri_s <= w_tri_s;
            r_valid    <= r_s1_valid && enable;
            if (r_s1_valid && enable) r_audio <= sample_t'(w_out[15:0]);
        end
    end

    assign audio_data = r_audio;
    assign data_valid = r_valid;
    assign busy       = w_busy;

endmodule
